fpu_config_sequencer: RTL and testbench
=======================================

Name: fpu_config_sequencer

Overview:
Upstream control stage for the PE datapath that holds the FPU/crossbar configuration.
- Stores up to DEPTH configuration entries. Each entry holds an instruction word, crossbar-1 selects, crossbar-2 selects and a hold count.
- On start, steps through entries 0..last_idx_i, presenting each for hold+1 cycles.
- Drives the FPU datapath's crossbar select, crossbar enable and config_all inputs directly from registered outputs.

Parameters:
- INST_WIDTH, 64, width of instruction word (config_all).
- NUM_OUTPUTS_CB1, 16, number of crossbar-1 select fields.
- CFG_W_CB1, 4, bits per crossbar-1 select (clog2 of 14 inputs).
- NUM_OUTPUTS_CB2, 4, number of crossbar-2 select fields.
- CFG_W_CB2, 4, bits per crossbar-2 select (clog2 of 9 inputs).
- DEPTH, 8, number of entries; power of two, at least 2.
- HOLD_W, 8, width of per-entry hold count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en_i  in  1  write entry strobe.
- wr_addr_i  in  clog2(DEPTH)  entry index.
- wr_inst_i  in  INST_WIDTH  instruction word.
- wr_cb1_i  in  NUM_OUTPUTS_CB1*CFG_W_CB1  packed crossbar-1 selects.
- wr_cb2_i  in  NUM_OUTPUTS_CB2*CFG_W_CB2  packed crossbar-2 selects.
- wr_hold_i  in  HOLD_W  extra cycles to hold the entry.
- start_i  in  1  begin sequence.
- stop_i  in  1  abort sequence.
- loop_en_i  in  1  wrap to entry 0 after last_idx_i.
- last_idx_i  in  clog2(DEPTH)  final entry index.
- config_all_o  out  INST_WIDTH  current instruction word.
- config_cb1_o  out  NUM_OUTPUTS_CB1*CFG_W_CB1  current crossbar-1 selects.
- config_cb2_o  out  NUM_OUTPUTS_CB2*CFG_W_CB2  current crossbar-2 selects.
- cb1_en_o  out  1  crossbar-1 enable.
- cb2_en_o  out  1  crossbar-2 enable.
- cur_idx_o  out  clog2(DEPTH)  entry currently presented.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle completion pulse.
- wr_err_o  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all entries, all outputs, hold counter and index are 0; state IDLE.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - wr_en_i writes the entry at wr_addr_i on the clock edge.
  - start_i=1 and stop_i=0 moves to RUN next cycle with idx=0 and hold counter=0.
  - start_i and stop_i both high: stop wins, stay in IDLE.
- RUN:
  - Outputs show entry[idx] one cycle after idx changes (registered readout); cb1_en_o=cb2_en_o=busy_o=1.
  - Entry idx is presented for exactly hold+1 consecutive cycles (hold=0 means 1 cycle).
  - When the counter equals hold:
    - idx<last_idx_i: idx+1, counter cleared.
    - idx==last_idx_i with loop_en_i=1: idx=0, remain in RUN, no gap cycle.
    - idx==last_idx_i with loop_en_i=0: go to DONE.
  - last_idx_i and loop_en_i are sampled live each cycle.
  - stop_i=1 goes to IDLE next cycle. Enables and busy drop; config outputs and cur_idx_o freeze at their last value; done_o is not asserted.
  - start_i is ignored.
  - wr_en_i is not written; wr_err_o pulses the next cycle.
- DONE: one cycle. done_o=1, enables=0, busy=0, config outputs hold the last entry; then IDLE.
- Outputs in IDLE: enables stay 0; config outputs hold their last value so the downstream crossbars see stable selects.
- Reset mid-RUN: immediate return to reset values; the memory is also cleared.
- Total first-pass length of a sequence is the sum over entries 0..last of (hold_k+1) cycles in RUN.

Optional Feature:
FPU_CFG_SEQ_CNT_EN
- Defined: adds output run_cycles_o, 32 bits.
  - Cleared on IDLE→RUN.
  - Increments every RUN cycle; holds in DONE and IDLE; saturates at all-ones.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert rst_n=0 mid-operation → all outputs 0, busy_o=0, entries read back as 0 after a start with last_idx=0.
- Basic run: write entries 0..2 with inst 0xA0/0xA1/0xA2, holds 0/2/1, last_idx=2, start → config_all_o = A0 ×1, A1 ×3, A2 ×2 cycles; enables high for exactly 6 cycles; done_o pulses the cycle after; busy_o low.
- Loop: same entries, loop_en=1 → sequence A0,A1,A1,A1,A2,A2,A0… with no gap; assert stop_i → IDLE next cycle, outputs frozen on the current entry, no done_o.
- Write during RUN: wr_en_i to addr 1 with inst 0xFF while busy → wr_err_o pulse one cycle later; the next pass still shows 0xA1.
- Start/stop collision: start_i=stop_i=1 in IDLE → stays IDLE, busy_o=0; start_i during RUN → ignored, idx unaffected.
- FPU_CFG_SEQ_CNT_EN: basic run → run_cycles_o=6 after done_o, unchanged 10 cycles later, cleared to 0 then counting on the next start.

Source files
------------

// File: rtl/fpu_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_config_sequencer
// Description : Holds up to DEPTH FPU/crossbar configuration entries and
//               replays entries 0..last_idx_i, showing each one for hold+1
//               cycles. All outputs are registered and feed the PE datapath's
//               config_all, crossbar select and crossbar enable inputs.
//               Optional build macro FPU_CFG_SEQ_CNT_EN adds the 32-bit
//               saturating run_cycles_o counter of RUN cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_config_sequencer #(
  parameter int INST_WIDTH      = 64,
  parameter int NUM_OUTPUTS_CB1 = 16,
  parameter int CFG_W_CB1       = 4,
  parameter int NUM_OUTPUTS_CB2 = 4,
  parameter int CFG_W_CB2       = 4,
  parameter int DEPTH           = 8,
  parameter int HOLD_W          = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]             wr_addr_i,
  input  logic [INST_WIDTH-1:0]                wr_inst_i,
  input  logic [NUM_OUTPUTS_CB1*CFG_W_CB1-1:0] wr_cb1_i,
  input  logic [NUM_OUTPUTS_CB2*CFG_W_CB2-1:0] wr_cb2_i,
  input  logic [HOLD_W-1:0]                    wr_hold_i,
  input  logic                                 start_i,
  input  logic                                 stop_i,
  input  logic                                 loop_en_i,
  input  logic [$clog2(DEPTH)-1:0]             last_idx_i,
  output logic [INST_WIDTH-1:0]                config_all_o,
  output logic [NUM_OUTPUTS_CB1*CFG_W_CB1-1:0] config_cb1_o,
  output logic [NUM_OUTPUTS_CB2*CFG_W_CB2-1:0] config_cb2_o,
  output logic                                 cb1_en_o,
  output logic                                 cb2_en_o,
  output logic [$clog2(DEPTH)-1:0]             cur_idx_o,
  output logic                                 busy_o,
  output logic                                 done_o,
`ifdef FPU_CFG_SEQ_CNT_EN
  output logic [31:0]                          run_cycles_o,
`endif
  output logic                                 wr_err_o
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CB1_W = NUM_OUTPUTS_CB1 * CFG_W_CB1;
  localparam int c_CB2_W = NUM_OUTPUTS_CB2 * CFG_W_CB2;

  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [HOLD_W-1:0]  c_HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_idx;
  logic [HOLD_W-1:0]    r_cnt;

  // Configuration storage is built from flops so that reset can clear it.
  logic [INST_WIDTH-1:0] r_mem_inst [DEPTH];
  logic [c_CB1_W-1:0]    r_mem_cb1  [DEPTH];
  logic [c_CB2_W-1:0]    r_mem_cb2  [DEPTH];
  logic [HOLD_W-1:0]     r_mem_hold [DEPTH];

  logic                  w_wr_accept;
  logic [HOLD_W-1:0]     w_cur_hold;
  logic                  w_hold_done;
  logic                  w_at_last;

  // Writes are refused only while a sequence is running; DONE is a single
  // housekeeping cycle and is treated like IDLE for writes.
  assign w_wr_accept = wr_en_i && (r_state != ST_RUN);
  assign w_cur_hold  = r_mem_hold[r_idx];
  assign w_hold_done = (r_cnt == w_cur_hold);
  // last_idx_i is sampled live; an index already past it ends the pass.
  assign w_at_last   = !(r_idx < last_idx_i);

  // Entry storage: cleared by reset, written on accepted write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_cb1[i]  <= '0;
        r_mem_cb2[i]  <= '0;
        r_mem_hold[i] <= '0;
      end
    end else if (w_wr_accept) begin
      r_mem_inst[wr_addr_i] <= wr_inst_i;
      r_mem_cb1[wr_addr_i]  <= wr_cb1_i;
      r_mem_cb2[wr_addr_i]  <= wr_cb2_i;
      r_mem_hold[wr_addr_i] <= wr_hold_i;
    end
  end

  // Sequencer state machine with registered datapath-facing outputs. The
  // outputs show the entry addressed in the previous cycle, so a pass of
  // N RUN cycles produces N enabled output cycles followed by done_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      config_all_o <= '0;
      config_cb1_o <= '0;
      config_cb2_o <= '0;
      cb1_en_o     <= 1'b0;
      cb2_en_o     <= 1'b0;
      cur_idx_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      wr_err_o     <= 1'b0;
`ifdef FPU_CFG_SEQ_CNT_EN
      run_cycles_o <= '0;
`endif
    end else begin
      done_o   <= 1'b0;
      wr_err_o <= wr_en_i && (r_state == ST_RUN);

      case (r_state)
        ST_IDLE: begin
          // Config outputs keep their last value so the crossbars see
          // stable selects while disabled.
          cb1_en_o <= 1'b0;
          cb2_en_o <= 1'b0;
          busy_o   <= 1'b0;
          if (start_i && !stop_i) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_cnt   <= '0;
`ifdef FPU_CFG_SEQ_CNT_EN
            run_cycles_o <= '0;
`endif
          end
        end

        ST_RUN: begin
`ifdef FPU_CFG_SEQ_CNT_EN
          if (run_cycles_o != '1) begin
            run_cycles_o <= run_cycles_o + 32'd1;
          end
`endif
          if (stop_i) begin
            // Abort: drop enables, freeze selects and index, no done pulse.
            r_state  <= ST_IDLE;
            cb1_en_o <= 1'b0;
            cb2_en_o <= 1'b0;
            busy_o   <= 1'b0;
          end else begin
            config_all_o <= r_mem_inst[r_idx];
            config_cb1_o <= r_mem_cb1[r_idx];
            config_cb2_o <= r_mem_cb2[r_idx];
            cur_idx_o    <= r_idx;
            cb1_en_o     <= 1'b1;
            cb2_en_o     <= 1'b1;
            busy_o       <= 1'b1;
            if (!w_hold_done) begin
              r_cnt <= r_cnt + c_HOLD_ONE;
            end else begin
              r_cnt <= '0;
              if (!w_at_last) begin
                r_idx <= r_idx + c_IDX_ONE;
              end else if (loop_en_i) begin
                r_idx <= '0;
              end else begin
                r_state <= ST_DONE;
              end
            end
          end
        end

        ST_DONE: begin
          done_o   <= 1'b1;
          cb1_en_o <= 1'b0;
          cb2_en_o <= 1'b0;
          busy_o   <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_config_sequencer
// Description : Scoreboard bench for fpu_config_sequencer. Expected entries
//               are queued when a sequence is started and popped on every
//               enabled output cycle. Define FPU_CFG_SEQ_CNT_EN to also
//               check run_cycles_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_config_sequencer;

  localparam int INST_WIDTH      = 64;
  localparam int NUM_OUTPUTS_CB1 = 16;
  localparam int CFG_W_CB1       = 4;
  localparam int NUM_OUTPUTS_CB2 = 4;
  localparam int CFG_W_CB2       = 4;
  localparam int DEPTH           = 8;
  localparam int HOLD_W          = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en_i;
  logic [2:0]  wr_addr_i;
  logic [63:0] wr_inst_i;
  logic [63:0] wr_cb1_i;
  logic [15:0] wr_cb2_i;
  logic [7:0]  wr_hold_i;
  logic        start_i;
  logic        stop_i;
  logic        loop_en_i;
  logic [2:0]  last_idx_i;
  logic [63:0] config_all_o;
  logic [63:0] config_cb1_o;
  logic [15:0] config_cb2_o;
  logic        cb1_en_o;
  logic        cb2_en_o;
  logic [2:0]  cur_idx_o;
  logic        busy_o;
  logic        done_o;
  logic        wr_err_o;
`ifdef FPU_CFG_SEQ_CNT_EN
  logic [31:0] run_cycles_o;
`endif

  always #5 clk = ~clk;

  fpu_config_sequencer #(
    .INST_WIDTH      (INST_WIDTH),
    .NUM_OUTPUTS_CB1 (NUM_OUTPUTS_CB1),
    .CFG_W_CB1       (CFG_W_CB1),
    .NUM_OUTPUTS_CB2 (NUM_OUTPUTS_CB2),
    .CFG_W_CB2       (CFG_W_CB2),
    .DEPTH           (DEPTH),
    .HOLD_W          (HOLD_W)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_inst_i    (wr_inst_i),
    .wr_cb1_i     (wr_cb1_i),
    .wr_cb2_i     (wr_cb2_i),
    .wr_hold_i    (wr_hold_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .loop_en_i    (loop_en_i),
    .last_idx_i   (last_idx_i),
    .config_all_o (config_all_o),
    .config_cb1_o (config_cb1_o),
    .config_cb2_o (config_cb2_o),
    .cb1_en_o     (cb1_en_o),
    .cb2_en_o     (cb2_en_o),
    .cur_idx_o    (cur_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
`ifdef FPU_CFG_SEQ_CNT_EN
    .run_cycles_o (run_cycles_o),
`endif
    .wr_err_o     (wr_err_o)
  );

  typedef struct {
    logic [63:0] inst;
    logic [63:0] cb1;
    logic [15:0] cb2;
    logic [2:0]  idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_inst [8];
  logic [63:0] m_cb1  [8];
  logic [15:0] m_cb2  [8];
  logic [7:0]  m_hold [8];

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cb1_of(input logic [63:0] inst);
    return 64'h0123_4567_89AB_CDEF ^ {8{inst[7:0]}};
  endfunction

  function automatic logic [15:0] cb2_of(input logic [63:0] inst);
    return {2{inst[7:0]}} ^ 16'h5A5A;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writes one entry and mirrors it into the reference model.
  task automatic write_entry(input int a, input logic [63:0] inst, input logic [7:0] hold);
    wr_en_i   = 1'b1;
    wr_addr_i = a[2:0];
    wr_inst_i = inst;
    wr_cb1_i  = cb1_of(inst);
    wr_cb2_i  = cb2_of(inst);
    wr_hold_i = hold;
    step();
    wr_en_i   = 1'b0;
    m_inst[a] = inst;
    m_cb1[a]  = cb1_of(inst);
    m_cb2[a]  = cb2_of(inst);
    m_hold[a] = hold;
  endtask

  // Queues one full pass over entries 0..last as seen on the outputs.
  task automatic push_pass(input int last);
    exp_t e;
    for (int k = 0; k <= last; k++) begin
      for (int r = 0; r <= int'(m_hold[k]); r++) begin
        e.inst = m_inst[k];
        e.cb1  = m_cb1[k];
        e.cb2  = m_cb2[k];
        e.idx  = k[2:0];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (done_o) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard monitor: every enabled output cycle must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (cb1_en_o || cb2_en_o || busy_o)) begin
      en_cnt++;
      check("mon_cb1_en", {63'd0, cb1_en_o}, 64'd1);
      check("mon_cb2_en", {63'd0, cb2_en_o}, 64'd1);
      check("mon_busy",   {63'd0, busy_o},   64'd1);
      if (exp_q.size() == 0) begin
        check("mon_unexpected_en", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("mon_cfg_all", config_all_o, e.inst);
        check("mon_cfg_cb1", config_cb1_o, e.cb1);
        check("mon_cfg_cb2", {48'd0, config_cb2_o}, {48'd0, e.cb2});
        check("mon_cur_idx", {61'd0, cur_idx_o}, {61'd0, e.idx});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 8; i++) begin
      m_inst[i] = '0; m_cb1[i] = '0; m_cb2[i] = '0; m_hold[i] = '0;
    end
    rst_n = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_inst_i = '0;
    wr_cb1_i = '0; wr_cb2_i = '0; wr_hold_i = '0; start_i = 1'b0;
    stop_i = 1'b0; loop_en_i = 1'b0; last_idx_i = '0;

    // Reset state
    repeat (3) step();
    check("rst_cfg_all", config_all_o, 64'd0);
    check("rst_cfg_cb1", config_cb1_o, 64'd0);
    check("rst_cfg_cb2", {48'd0, config_cb2_o}, 64'd0);
    check("rst_en", {62'd0, cb1_en_o, cb2_en_o}, 64'd0);
    check("rst_busy_done_err", {61'd0, busy_o, done_o, wr_err_o}, 64'd0);
    check("rst_cur_idx", {61'd0, cur_idx_o}, 64'd0);
    rst_n = 1'b1;
    step();

    // Basic run: A0 x1, A1 x3, A2 x2
    write_entry(0, 64'hA0, 8'd0);
    write_entry(1, 64'hA1, 8'd2);
    write_entry(2, 64'hA2, 8'd1);
    check("idle_wr_no_err", {63'd0, wr_err_o}, 64'd0);
    last_idx_i = 3'd2;
    loop_en_i  = 1'b0;
    en_cnt = 0;
    push_pass(2);
    do_start();
    wait_done(40, lat);
    check("basic_done_lat", lat, 64'd7);
    check("basic_en_cycles", en_cnt, 64'd6);
    check("basic_q_empty", exp_q.size(), 64'd0);
    check("basic_busy_at_done", {63'd0, busy_o}, 64'd0);
    check("basic_en_at_done", {63'd0, cb1_en_o}, 64'd0);
    check("basic_hold_cfg", config_all_o, 64'hA2);
    check("basic_hold_idx", {61'd0, cur_idx_o}, 64'd2);
`ifdef FPU_CFG_SEQ_CNT_EN
    check("cnt_after_done", run_cycles_o, 64'd6);
`endif
    step();
    check("basic_done_one_cycle", {63'd0, done_o}, 64'd0);
    repeat (9) step();
`ifdef FPU_CFG_SEQ_CNT_EN
    check("cnt_holds_idle", run_cycles_o, 64'd6);
`endif
    check("idle_cfg_stable", config_all_o, 64'hA2);

    // Loop run, stopped after nine enabled cycles (A0,A1,A1,A1,A2,A2,A0,A1,A1)
    loop_en_i = 1'b1;
    en_cnt = 0;
    push_pass(2);
    exp_q.push_back('{inst: m_inst[0], cb1: m_cb1[0], cb2: m_cb2[0], idx: 3'd0});
    exp_q.push_back('{inst: m_inst[1], cb1: m_cb1[1], cb2: m_cb2[1], idx: 3'd1});
    exp_q.push_back('{inst: m_inst[1], cb1: m_cb1[1], cb2: m_cb2[1], idx: 3'd1});
    do_start();
    repeat (9) step();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    check("stop_busy", {63'd0, busy_o}, 64'd0);
    check("stop_en", {62'd0, cb1_en_o, cb2_en_o}, 64'd0);
    check("stop_freeze_cfg", config_all_o, 64'hA1);
    check("stop_freeze_idx", {61'd0, cur_idx_o}, 64'd1);
    check("loop_en_cycles", en_cnt, 64'd9);
    check("loop_q_empty", exp_q.size(), 64'd0);
    lat = 0;
    repeat (4) begin
      step();
      if (done_o) lat++;
    end
    check("stop_no_done", lat, 64'd0);
    loop_en_i = 1'b0;

    // Write during RUN is rejected and flagged one cycle later
    en_cnt = 0;
    push_pass(2);
    do_start();
`ifdef FPU_CFG_SEQ_CNT_EN
    check("cnt_cleared_on_start", run_cycles_o, 64'd0);
`endif
    step();
`ifdef FPU_CFG_SEQ_CNT_EN
    check("cnt_counting", run_cycles_o, 64'd1);
`endif
    wr_en_i = 1'b1; wr_addr_i = 3'd1; wr_inst_i = 64'hFF;
    wr_cb1_i = '1; wr_cb2_i = '1; wr_hold_i = 8'd5;
    step();
    wr_en_i = 1'b0;
    check("run_wr_err_pulse", {63'd0, wr_err_o}, 64'd1);
    step();
    check("run_wr_err_clear", {63'd0, wr_err_o}, 64'd0);
    wait_done(40, lat);
    check("wr_run_en_cycles", en_cnt, 64'd6);
    step();
    en_cnt = 0;
    push_pass(2);
    do_start();
    wait_done(40, lat);
    check("wr_rejected_pass_lat", lat, 64'd7);
    check("wr_rejected_q_empty", exp_q.size(), 64'd0);
    step();

    // start/stop collision in IDLE stays idle
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    check("collide_busy", {63'd0, busy_o}, 64'd0);
    step();
    check("collide_still_idle", {62'd0, busy_o, cb1_en_o}, 64'd0);

    // start during RUN is ignored
    en_cnt = 0;
    push_pass(2);
    do_start();
    repeat (2) step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done(40, lat);
    check("restart_ignored_lat", lat, 64'd4);
    check("restart_ignored_cycles", en_cnt, 64'd6);
    check("restart_q_empty", exp_q.size(), 64'd0);
    step();

    // Asynchronous reset mid-RUN clears outputs and memory
    loop_en_i = 1'b1;
    push_pass(2);
    do_start();
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_cfg_all", config_all_o, 64'd0);
    check("arst_busy_en", {62'd0, busy_o, cb1_en_o}, 64'd0);
    check("arst_cur_idx", {61'd0, cur_idx_o}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      m_inst[i] = '0; m_cb1[i] = '0; m_cb2[i] = '0; m_hold[i] = '0;
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    loop_en_i  = 1'b0;
    last_idx_i = 3'd0;
    en_cnt = 0;
    push_pass(0);
    do_start();
    wait_done(20, lat);
    check("arst_pass_lat", lat, 64'd2);
    check("arst_pass_cycles", en_cnt, 64'd1);
    check("arst_q_empty", exp_q.size(), 64'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
